multicycle_ctrl: RTL
====================

# multicycle_ctrl

Multi-cycle control unit for the RV32I core. It sequences one instruction at a time through fetch, decode, execute, memory and writeback. It drives every datapath write-enable and mux select around the decoder, ALU, register file and PC, and handshakes with a single shared instruction/data memory port. It also counts retired instructions and traps on illegal opcodes.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- opcode  in  5  IR[6:2], valid from DECODE onward
- instr_lo  in  2  IR[1:0]; must be 2'b11 for a legal instruction
- branch_taken  in  1  comparator result, valid in EXEC
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request, held high until mem_ready
- mem_we  out  1  1 = store, 0 = read
- addr_sel  out  1  0 = PC, 1 = ALU result
- ir_we  out  1  latch IR and old_pc
- pc_we  out  1  write PC
- pc_sel  out  2  0 = PC+4, 1 = old_pc+imm, 2 = ALU result (JALR)
- rf_we  out  1  register-file write
- wb_sel  out  2  0 = ALU, 1 = memory data, 2 = old_pc+4
- trap  out  1  illegal instruction, sticky
- retire  out  1  one-cycle pulse per completed instruction
- instret  out  CNT_W  count of retired instructions

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- FETCH: mem_req=1, mem_we=0, addr_sel=0.
  - On mem_ready: ir_we=1, pc_we=1, pc_sel=0, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: register-file read.
  - If instr_lo≠2'b11 or opcode is not one of LOAD, STORE, BRANCH, JAL, JALR, REG, IMM, LUI or AUIPC, go to TRAP.
  - Otherwise go to EXEC.
- EXEC, by opcode:
  - LOAD, STORE: go to MEM.
  - BRANCH: pc_we=branch_taken, pc_sel=1, retire=1, then go to FETCH.
  - JAL: pc_we=1, pc_sel=1, then go to WB.
  - JALR: pc_we=1, pc_sel=2, then go to WB.
  - REG, IMM, LUI, AUIPC: go to WB.
- MEM: mem_req=1, addr_sel=1, mem_we=(opcode==STORE).
  - On mem_ready with LOAD: go to WB.
  - On mem_ready with STORE: retire=1, then go to FETCH.
  - Otherwise stay in MEM.
- WB: rf_we=1, retire=1, then go to FETCH.
  - wb_sel=1 for LOAD, 2 for JAL/JALR, 0 otherwise.
  - rd=x0 suppression is the register file's job.
- TRAP: all enables 0 and trap=1. Stays in TRAP until rst.
- instret increments on every retire pulse and wraps modulo 2^CNT_W; there is no saturation.
- Outputs not listed for a state are 0.

## Timing
- Reset: state=FETCH and instret=0.
  - trap, retire, mem_req, mem_we, ir_we, pc_we and rf_we are 0 during the reset cycle.
  - mem_req goes to 1 on the first cycle after rst deasserts.
- The state register updates on the clock edge.
- mem_req, mem_we, addr_sel, rf_we and wb_sel are decoded from the state register (Moore).
- ir_we, pc_we in FETCH, pc_sel in FETCH, and the MEM-state retire are combinational on mem_ready (Mealy).
- Cycle counts with zero-wait memory (mem_ready=1 in the first request cycle):
  - REG/IMM/LUI/AUIPC/JAL/JALR: 4 cycles
  - LOAD: 5 cycles
  - STORE: 4 cycles
  - BRANCH: 3 cycles
- Each wait cycle adds 1 cycle.
- While mem_req=1 and mem_ready=0, mem_we and addr_sel are stable.
- mem_ready while mem_req=0 is ignored.
- Reset mid-request: the request is dropped the same cycle; memory tolerates abandoned requests.
- The same reset applies in TRAP; reset in any state returns to FETCH.
- instret is updated one edge after the retire pulse.
- A retire pulse and an instret wrap in the same cycle behave normally: instret goes from all-ones to 0.

## Structure
- Shared package core_pkg holds:
  - opcode constants (OP_LOAD … OP_IMM, shared with the decoder)
  - state encoding (3 bits)
  - PC_SEL_* constants
  - WB_SEL_* constants
  - ADDR_SEL_* constants
- One sub-module, retire_counter: a CNT_W-bit counter with clk, rst, inc and count ports.
- All other logic is in a single FSM with a next-state/output always block.

## Test plan
- ADDI with zero-wait memory → FETCH, DECODE, EXEC, WB in 4 cycles.
  - ir_we and pc_we (pc_sel=0) high in cycle 1.
  - rf_we=1, wb_sel=0 and retire=1 in cycle 4.
  - instret goes 0→1.
- LW, with mem_ready low for 3 cycles in MEM → mem_req held 4 cycles with addr_sel=1 and mem_we=0.
  - Then WB with wb_sel=1; total 8 cycles.
- BEQ → 3 cycles, with pc_we=1 and pc_sel=1 in EXEC.
  - With branch_taken=0: pc_we=0 in EXEC, retire=1, rf_we never asserted.
- JALR → pc_we=1 and pc_sel=2 in EXEC, then WB with rf_we=1 and wb_sel=2.
- Opcode 5'b11111 or instr_lo=2'b01 → TRAP after DECODE, with trap=1 and no further mem_req.
  - rst then returns to FETCH with instret=0.
- rst asserted mid-FETCH with mem_req=1 → mem_req=0 in the same cycle, FETCH next cycle.
  - Preload instret to all-ones, retire one instruction → instret=0.

Source files
------------

// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// core_pkg : shared RV32I opcode map and multicycle-controller encodings
// Rev 1.0  : initial release
// ============================================================================
package core_pkg;

    // IR[6:2] major opcodes, shared with the decoder
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_REG    = 5'b01100;
    localparam logic [4:0] OP_IMM    = 5'b00100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;

    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] S_FETCH  = 3'd0;
    localparam logic [STATE_W-1:0] S_DECODE = 3'd1;
    localparam logic [STATE_W-1:0] S_EXEC   = 3'd2;
    localparam logic [STATE_W-1:0] S_MEM    = 3'd3;
    localparam logic [STATE_W-1:0] S_WB     = 3'd4;
    localparam logic [STATE_W-1:0] S_TRAP   = 3'd5;

    localparam logic [1:0] PC_SEL_PC4 = 2'd0;  // PC + 4
    localparam logic [1:0] PC_SEL_REL = 2'd1;  // old_pc + imm
    localparam logic [1:0] PC_SEL_ALU = 2'd2;  // ALU result (JALR)

    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC4 = 2'd2;

    localparam logic ADDR_SEL_PC  = 1'b0;
    localparam logic ADDR_SEL_ALU = 1'b1;

    function automatic logic is_legal_op(input logic [4:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR,
            OP_REG, OP_IMM, OP_LUI, OP_AUIPC: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/retire_counter.sv
`default_nettype none
// ============================================================================
// retire_counter : free-running retired-instruction counter, wraps modulo 2^CNT_W
// Rev 1.0        : initial release
// ============================================================================
module retire_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// multicycle_ctrl : RV32I fetch/decode/exec/mem/wb sequencer with shared memory port
// Rev 1.0         : initial release
// ============================================================================
module multicycle_ctrl
    import core_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       opcode,
    input  logic [1:0]       instr_lo,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic             trap,
    output logic             retire,
    output logic [CNT_W-1:0] instret
);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = ADDR_SEL_PC;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = PC_SEL_PC4;
        rf_we    = 1'b0;
        wb_sel   = WB_SEL_ALU;
        trap     = 1'b0;
        retire   = 1'b0;

        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we  = 1'b1;
                    pc_we  = 1'b1;
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                w_next = (instr_lo == 2'b11 && is_legal_op(opcode)) ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                case (opcode)
                    OP_LOAD, OP_STORE: w_next = S_MEM;
                    OP_BRANCH: begin
                        pc_we  = branch_taken;
                        pc_sel = PC_SEL_REL;
                        retire = 1'b1;
                        w_next = S_FETCH;
                    end
                    OP_JAL: begin
                        pc_we  = 1'b1;
                        pc_sel = PC_SEL_REL;
                        w_next = S_WB;
                    end
                    OP_JALR: begin
                        pc_we  = 1'b1;
                        pc_sel = PC_SEL_ALU;
                        w_next = S_WB;
                    end
                    // REG/IMM/LUI/AUIPC; anything else was trapped in DECODE
                    default: w_next = S_WB;
                endcase
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = ADDR_SEL_ALU;
                mem_we   = (opcode == OP_STORE);
                if (mem_ready) begin
                    if (opcode == OP_STORE) begin
                        retire = 1'b1;
                        w_next = S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we  = 1'b1;
                retire = 1'b1;
                if (opcode == OP_LOAD) begin
                    wb_sel = WB_SEL_MEM;
                end else if (opcode == OP_JAL || opcode == OP_JALR) begin
                    wb_sel = WB_SEL_PC4;
                end
                w_next = S_FETCH;
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase

        // Reset drops any in-flight request in the same cycle
        if (rst) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            ir_we   = 1'b0;
            pc_we   = 1'b0;
            rf_we   = 1'b0;
            trap    = 1'b0;
            retire  = 1'b0;
        end
    end

    retire_counter #(
        .CNT_W (CNT_W)
    ) u_retire_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (retire),
        .count (instret)
    );

endmodule
`default_nettype wire
